mem_wb_stage: RTL

Parametrised MEM/WB pipeline stage for the pipeline processor. It replaces the plain always-enabled MEM/WB register with an elastic stage:
- a valid/ready handshake on both sides, backed by a two-entry skid buffer;
- a synchronous flush;
- an integrated write-back source mux that drives the register-file write port directly;
- a retired-instruction counter.

It sits between the memory stage and the register file.

---
 rtl/wb_pkg.sv | 35 +++
 rtl/pipe_skid_buf.sv | 72 +++++++
 rtl/mem_wb_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB stage: write-back source select and the payload
// carried through the skid buffer.
package wb_pkg;

  localparam int WB_PC_W       = 9;
  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int WB_SRC_W      = 3;

  typedef enum logic [WB_SRC_W-1:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_PC4   = 3'd2,
    WB_IMM   = 3'd3,
    WB_PCIMM = 3'd4
  } wb_src_e;

  // reg_wrt_src stays a raw 3-bit field so the unused codes 101..111 survive
  typedef struct packed {
    logic [WB_DATA_W-1:0]     mem_rd_data;
    logic [WB_DATA_W-1:0]     alu_result;
    logic [WB_PC_W-1:0]       pc;
    logic [WB_DATA_W-1:0]     imm;
    logic                     reg_wrt_en;
    logic [WB_SRC_W-1:0]      reg_wrt_src;
    logic [WB_REG_ADDR_W-1:0] reg_dst;
  } wb_payload_t;

  localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

  function automatic logic is_x0(input logic [WB_REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic buffer: main drives the output, skid absorbs the one beat
// that can arrive while main is stalled. in_ready is the registered ~skid_valid.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & ~skid_valid;
  // main can take a new beat at this edge: empty, or its beat is committing
  assign main_free = ~main_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_free) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= accept;
          if (accept) begin
            main_data <= in_data;
          end
        end
      end

      if (skid_valid) begin
        if (main_free) begin
          skid_valid <= accept;
          if (accept) begin
            skid_data <= in_data;
          end
        end
      end else if (accept && !main_free) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

  a_stall_holds_main : assert property (
    @(posedge clk) disable iff (rst)
    (main_valid && !out_ready) |=> $stable(main_data)
  );

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB stage: skid-buffered handshake, write-back source mux driving
// the register-file write port, and a retired-instruction counter.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DM_ADDRESS-1:0] pc,
  input  logic [DATA_W-1:0]     imm,
  input  logic                  reg_wrt_en,
  input  logic [2:0]            reg_wrt_src,
  input  logic [REG_ADDR_W-1:0] reg_dst,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [DM_ADDRESS-1:0] out_pc,
  output logic [CNT_W-1:0]      retired
);

  wb_payload_t in_payload;
  wb_payload_t main;
  logic        commit;

  always_comb begin
    in_payload             = '0;
    in_payload.mem_rd_data = mem_rd_data;
    in_payload.alu_result  = alu_result;
    in_payload.pc          = pc;
    in_payload.imm         = imm;
    in_payload.reg_wrt_en  = reg_wrt_en;
    in_payload.reg_wrt_src = reg_wrt_src;
    in_payload.reg_dst     = reg_dst;
  end

  pipe_skid_buf #(
    .W (WB_PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main)
  );

  // reset and flush both swallow the head beat, so neither may write or count
  assign commit = out_valid & out_ready & ~flush & ~rst;

  always_comb begin
    rf_wdata = '0;
    case (main.reg_wrt_src)
      WB_ALU:   rf_wdata = main.alu_result;
      WB_MEM:   rf_wdata = main.mem_rd_data;
      WB_PC4:   rf_wdata = DATA_W'(main.pc) + DATA_W'(4);
      WB_IMM:   rf_wdata = main.imm;
      WB_PCIMM: rf_wdata = DATA_W'(main.pc) + main.imm;
      default:  rf_wdata = '0;
    endcase
  end

  assign rf_we    = commit & main.reg_wrt_en & ~is_x0(main.reg_dst);
  assign rf_waddr = main.reg_dst;
  assign out_pc   = main.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (commit) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule
